clock_factor_calc: RTL

- Upstream configuration stage for the fractional clock divider interface.
- Takes a requested division ratio (dividend/divisor) and computes quotient and remainder with an iterative restoring divider.
- Validates the ratio, then publishes dividend, divisor, quotient and remainder together as one atomic register set. These drive the divider's i_clk_dividend, i_clk_divisor, i_clk_quotient and i_clk_remainder inputs.

---
 rtl/clock_factor_pkg.sv | 20 ++
 rtl/clock_factor_divider.sv | 66 ++++++
 rtl/clock_factor_calc.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/clock_factor_pkg.sv
// Shared types and constants for the clock factor calculator (state encoding,
// safe divide-by-1 reset set, minimum legal quotient).
package clock_factor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DIV    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Published set after reset: divide-by-1, same as the downstream divider default
    localparam int unsigned RST_DIVIDEND  = 1;
    localparam int unsigned RST_DIVISOR   = 1;
    localparam int unsigned RST_QUOTIENT  = 1;
    localparam int unsigned RST_REMAINDER = 0;

    localparam int unsigned MIN_QUOTIENT  = 2;

endpackage

// File: rtl/clock_factor_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first,
// FACTOR_BIT steps after i_start. o_done marks the cycle of the final step.
module clock_factor_divider
    import clock_factor_pkg::*;
#(
    parameter int FACTOR_BIT = 31
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [FACTOR_BIT-1:0] i_dividend,
    input  logic [FACTOR_BIT-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [FACTOR_BIT-1:0] o_quotient,
    output logic [FACTOR_BIT-1:0] o_remainder
);

    localparam int               CW        = $clog2(FACTOR_BIT + 1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(FACTOR_BIT - 1);

    // The stored remainder is always < divisor, so only the shifted value needs the extra bit
    logic [FACTOR_BIT-1:0] r_rem;
    logic [FACTOR_BIT-1:0] r_quo;
    logic [FACTOR_BIT-1:0] r_dsr;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;

    logic [FACTOR_BIT:0]   w_rem_sh;
    logic [FACTOR_BIT:0]   w_rem_sub;
    logic                  w_ge;

    assign w_rem_sh  = {r_rem, r_quo[FACTOR_BIT-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_sub = w_rem_sh - {1'b0, r_dsr};

    // Dividend bits shift out of r_quo's MSB while quotient bits shift into its LSB
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_dsr  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_rem_sub[FACTOR_BIT-1:0] : w_rem_sh[FACTOR_BIT-1:0];
            r_quo  <= {r_quo[FACTOR_BIT-2:0], w_ge};
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_busy && (r_cnt == LAST_STEP);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/clock_factor_calc.sv
// Validates a requested division ratio, divides it, and publishes dividend/divisor/
// quotient/remainder atomically. Optional macro CLOCK_FACTOR_AUTO_REQ_EN adds self-start on input change.
module clock_factor_calc
    import clock_factor_pkg::*;
#(
    parameter int FACTOR_BIT = 31
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req,
    input  logic [FACTOR_BIT-1:0] i_dividend,
    input  logic [FACTOR_BIT-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_exact,
    output logic [FACTOR_BIT-1:0] o_clk_dividend,
    output logic [FACTOR_BIT-1:0] o_clk_divisor,
    output logic [FACTOR_BIT-1:0] o_clk_quotient,
    output logic [FACTOR_BIT-1:0] o_clk_remainder
);

    localparam logic [FACTOR_BIT:0] MINQ = (FACTOR_BIT + 1)'(MIN_QUOTIENT);

    state_t                r_state;
    state_t                w_state_nx;
    logic [FACTOR_BIT-1:0] r_sh_dividend;
    logic [FACTOR_BIT-1:0] r_sh_divisor;
    logic                  r_done;
    logic                  r_err;
    logic                  r_exact;
    logic [FACTOR_BIT-1:0] r_pub_dividend;
    logic [FACTOR_BIT-1:0] r_pub_divisor;
    logic [FACTOR_BIT-1:0] r_pub_quotient;
    logic [FACTOR_BIT-1:0] r_pub_remainder;

    logic                  w_self_start;
    logic                  w_launch;
    logic                  w_reject;
    logic [FACTOR_BIT:0]   w_min_dividend;
    logic                  w_capture;
    logic                  w_fail;
    logic                  w_div_start;
    logic                  w_commit;
    logic                  w_div_busy;
    logic                  w_div_done;
    logic [FACTOR_BIT-1:0] w_div_quotient;
    logic [FACTOR_BIT-1:0] w_div_remainder;

`ifdef CLOCK_FACTOR_AUTO_REQ_EN
    assign w_self_start = (i_dividend != r_sh_dividend) || (i_divisor != r_sh_divisor);
`else
    assign w_self_start = 1'b0;
`endif

    assign w_launch       = i_req || w_self_start;
    assign w_min_dividend = {1'b0, r_sh_divisor} * MINQ;
    assign w_reject       = (r_sh_divisor == '0) || ({1'b0, r_sh_dividend} < w_min_dividend);

    clock_factor_divider #(
        .FACTOR_BIT (FACTOR_BIT)
    ) u_divider (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_start     (w_div_start),
        .i_dividend  (r_sh_dividend),
        .i_divisor   (r_sh_divisor),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quotient),
        .o_remainder (w_div_remainder)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (w_launch) w_state_nx = ST_CHECK;
            ST_CHECK:  w_state_nx = w_reject ? ST_IDLE : ST_DIV;
            ST_DIV:    if (w_div_done) w_state_nx = ST_COMMIT;
            ST_COMMIT: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture   = 1'b0;
        w_fail      = 1'b0;
        w_div_start = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE:   w_capture   = w_launch;
            ST_CHECK: begin
                w_fail      = w_reject;
                w_div_start = !w_reject;
            end
            ST_COMMIT: w_commit    = 1'b1;
            default:   ;
        endcase
    end

    // Shadow copy of the request; later input changes cannot disturb a calculation
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sh_dividend <= FACTOR_BIT'(RST_DIVIDEND);
            r_sh_divisor  <= FACTOR_BIT'(RST_DIVISOR);
        end else if (w_capture) begin
            r_sh_dividend <= i_dividend;
            r_sh_divisor  <= i_divisor;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pub_dividend  <= FACTOR_BIT'(RST_DIVIDEND);
            r_pub_divisor   <= FACTOR_BIT'(RST_DIVISOR);
            r_pub_quotient  <= FACTOR_BIT'(RST_QUOTIENT);
            r_pub_remainder <= FACTOR_BIT'(RST_REMAINDER);
            r_exact         <= 1'b1;
        end else if (w_commit) begin
            r_pub_dividend  <= r_sh_dividend;
            r_pub_divisor   <= r_sh_divisor;
            r_pub_quotient  <= w_div_quotient;
            r_pub_remainder <= w_div_remainder;
            r_exact         <= (w_div_remainder == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_fail || w_commit;
            if (w_fail) begin
                r_err <= 1'b1;
            end else if (w_commit) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_busy          = (r_state != ST_IDLE) || w_div_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_exact         = r_exact;
    assign o_clk_dividend  = r_pub_dividend;
    assign o_clk_divisor   = r_pub_divisor;
    assign o_clk_quotient  = r_pub_quotient;
    assign o_clk_remainder = r_pub_remainder;

endmodule
